// File: rtl/riscv_core_pkg.sv
// Shared RISC-V core constants: datapath width and M-extension divide funct3 encodings.
package riscv_core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Every divide/remainder funct3 has bit 2 set; MUL-group encodings do not.
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Combinational detection and result of divide special cases (divide by zero,
// signed overflow MIN_INT / -1) so the controller can answer without the divider.
module div_special_case
    import riscv_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  special_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [DATA_WIDTH-1:0] min_int;
    logic                  div_zero;
    logic                  overflow;

    always_comb begin
        min_int   = '0;
        min_int[DATA_WIDTH-1] = 1'b1;
        div_zero  = (b_i == '0);
        // op_i[0]==0 selects the signed forms (DIV, REM)
        overflow  = !op_i[0] && (a_i == min_int) && (b_i == '1);
        special_o = is_div_op(op_i) && (div_zero || overflow);
        result_o  = '0;
        if (div_zero) begin
            result_o = op_i[1] ? a_i : '1;
        end else if (overflow) begin
            result_o = op_i[1] ? '0 : min_int;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/writeback controller wrapping an iterative divider.
// Optional fast path for divide special cases: define DIV_ISSUE_FASTPATH_EN.
module div_issue_ctrl
    import riscv_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_op_i,
    input  logic [DATA_WIDTH-1:0] req_a_i,
    input  logic [DATA_WIDTH-1:0] req_b_i,
    input  logic [REG_ADDR_W-1:0] req_rd_i,
    input  logic                  flush_i,
    output logic                  div_start_o,
    output logic [2:0]            div_op_o,
    output logic [DATA_WIDTH-1:0] div_a_o,
    output logic [DATA_WIDTH-1:0] div_b_o,
    input  logic [DATA_WIDTH-1:0] div_result_i,
    input  logic                  div_done_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_result_o,
    output logic [REG_ADDR_W-1:0] rsp_rd_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  fp_special;
    logic [DATA_WIDTH-1:0] fp_result;
    logic                  accept;

`ifdef DIV_ISSUE_FASTPATH_EN
    div_special_case #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_special (
        .op_i      (req_op_i),
        .a_i       (req_a_i),
        .b_i       (req_b_i),
        .special_o (fp_special),
        .result_o  (fp_result)
    );
`else
    assign fp_special = 1'b0;
    assign fp_result  = '0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        result_d    = result_q;
        div_start_o = 1'b0;
        req_ready_o = (state_q == S_IDLE) && !flush_i;
        accept      = req_valid_i && req_ready_o;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = req_op_i;
                    a_d  = req_a_i;
                    b_d  = req_b_i;
                    rd_d = req_rd_i;
                    if (!is_div_op(req_op_i)) begin
                        result_d = '0;
                        state_d  = S_RESP;
                    end else if (fp_special) begin
                        result_d = fp_result;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    div_start_o = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done arriving with the flush is the killed op's own result, so
                // there is nothing left to drain.
                if (flush_i) begin
                    state_d = div_done_i ? S_IDLE : S_DRAIN;
                end else if (div_done_i) begin
                    result_d = div_result_i;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

    assign div_op_o     = op_q;
    assign div_a_o      = a_q;
    assign div_b_o      = b_q;
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_result_o = result_q;
    assign rsp_rd_o     = rd_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: behavioural divider model plus a
// response scoreboard; fast-path expectations follow DIV_ISSUE_FASTPATH_EN.
module tb_div_issue_ctrl;
    import riscv_core_pkg::*;

`ifdef DIV_ISSUE_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o;
    logic [2:0]  req_op_i;
    logic [31:0] req_a_i, req_b_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        div_start_o;
    logic [2:0]  div_op_o;
    logic [31:0] div_a_o, div_b_o;
    logic [31:0] div_result_i;
    logic        div_done_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic [4:0]  rsp_rd_o;
    logic        busy_o;

    div_issue_ctrl #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rd_i(req_rd_i),
        .flush_i(flush_i),
        .div_start_o(div_start_o), .div_op_o(div_op_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_result_i(div_result_i), .div_done_i(div_done_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_rd_o(rsp_rd_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            F3_DIV:  return 32'(sa / sb);
            F3_DIVU: return a / b;
            F3_REM:  return 32'(sa % sb);
            F3_REMU: return a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Divider model: done_o pulses dly_cfg cycles after start_i.
    int          dly_cfg = 4;
    int          dcnt = 0;
    logic [31:0] dres = '0;
    logic        extra_done = 1'b0;

    always @(posedge clk_i) begin
        if (div_start_o) begin
            dcnt <= dly_cfg;
            dres <= ref_div(div_op_o, div_a_o, div_b_o);
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    end
    assign div_done_i   = (dcnt == 1) || extra_done;
    assign div_result_i = dres;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [4:0] rd; logic [31:0] res; } exp_t;
    exp_t sb[$];

    int   start_cnt = 0, start_cyc = 0, valid_rise_cnt = 0, hs_cnt = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk_i) begin
        exp_t e;
        if (div_start_o) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (rsp_valid_o && !prev_valid) valid_rise_cnt++;
        prev_valid = rsp_valid_o;
        if (rsp_valid_o && rsp_ready_i && !flush_i) begin
            hs_cnt++;
            check_val("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("rsp", 64'({rsp_rd_o, rsp_result_o}), 64'({e.rd, e.res}));
            end
        end
    end

    int acc_cyc;

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        bit   ok = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b; req_rd_i = rd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                ok = 1'b1;
                acc_cyc = cyc;
                e.rd  = rd;
                e.res = op[2] ? ref_div(op, a, b) : 32'd0;
                sb.push_back(e);
                break;
            end
        end
        check_val("accepted", 64'(ok), 64'(1));
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int vcyc);
        vcyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                vcyc = cyc;
                break;
            end
        end
        check_val("valid_seen", 64'(rsp_valid_o), 64'(1));
    endtask

    task automatic wait_idle(input bit rnd_ready);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i); #1;
            if (rnd_ready) rsp_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            if (!busy_o) break;
        end
        check_val("idle_seen", 64'(busy_o), 64'(0));
        rsp_ready_i = 1'b1;
    endtask

    // Issue with rsp_ready_i high and check launch count and response latency.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int  s0, vcyc;
        bit  quick;
        quick = !op[2] || (FAST && is_special(op, a, b));
        s0 = start_cnt;
        issue(op, a, b, rd);
        wait_valid(vcyc);
        check_val({tag, "_lat"}, 64'(vcyc - acc_cyc), quick ? 64'(1) : 64'(dly_cfg + 2));
        check_val({tag, "_starts"}, 64'(start_cnt - s0), quick ? 64'(0) : 64'(1));
        wait_idle(1'b0);
    endtask

    initial begin
        int s0, vr0, hs0, vcyc;
        rst_ni = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
        req_rd_i = '0; flush_i = 1'b0; rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_val("rst_ready", 64'(req_ready_o), 64'(1));
        check_val("rst_busy", 64'(busy_o), 64'(0));
        check_val("rst_start", 64'(div_start_o), 64'(0));
        check_val("rst_valid", 64'(rsp_valid_o), 64'(0));
        check_val("rst_dops", 64'({div_op_o, div_a_o, div_b_o}), 64'(0));
        check_val("rst_rsp", 64'({rsp_rd_o, rsp_result_o}), 64'(0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // DIVU 100/7 with writeback back-pressure for 10 cycles
        dly_cfg = 4; rsp_ready_i = 1'b0; s0 = start_cnt;
        issue(F3_DIVU, 32'd100, 32'd7, 5'd3);
        wait_valid(vcyc);
        check_val("divu_start_cnt", 64'(start_cnt - s0), 64'(1));
        check_val("divu_start_cyc", 64'(start_cyc - acc_cyc), 64'(1));
        check_val("divu_lat", 64'(vcyc - acc_cyc), 64'(6));
        check_val("divu_hold_ops", 64'({div_op_o, div_a_o}), 64'({F3_DIVU, 32'd100}));
        for (int i = 0; i < 10; i++) begin
            check_val("hold_valid", 64'(rsp_valid_o), 64'(1));
            check_val("hold_data", 64'({rsp_rd_o, rsp_result_o}), 64'({5'd3, 32'd14}));
            check_val("hold_ready", 64'(req_ready_o), 64'(0));
            @(negedge clk_i);
        end
        hs0 = hs_cnt;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        wait_idle(1'b0);
        check_val("one_handshake", 64'(hs_cnt - hs0), 64'(1));
        check_val("idle_ready", 64'(req_ready_o), 64'(1));

        // Special cases, non-divide ops, ordinary signed ops
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        run_op("remu_z", F3_REMU, 32'h0000_1234, 32'd0, 5'd9);
        run_op("divu_z", F3_DIVU, 32'h0000_1234, 32'd0, 5'd10);
        run_op("div_z", F3_DIV, 32'hFFFF_FFF0, 32'd0, 5'd11);
        run_op("op010", 3'b010, 32'd55, 32'd3, 5'd12);
        run_op("div_neg", F3_DIV, 32'hFFFF_FF9C, 32'd7, 5'd13);
        run_op("rem_neg", F3_REM, 32'hFFFF_FF9C, 32'd7, 5'd14);

        // Flush in WAIT; done arrives 2 cycles later and is drained
        dly_cfg = 3; vr0 = valid_rise_cnt;
        issue(F3_DIV, 32'd50, 32'd5, 5'd9);
        void'(sb.pop_back());
        @(posedge clk_i); #1; flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
        @(negedge clk_i);
        check_val("drain_busy", 64'(busy_o), 64'(1));
        @(negedge clk_i);
        @(negedge clk_i);
        check_val("drain_idle", 64'(busy_o), 64'(0));
        check_val("drain_no_rsp", 64'(valid_rise_cnt - vr0), 64'(0));
        run_op("after_drain", F3_DIVU, 32'd81, 32'd9, 5'd2);

        // Flush coincident with done
        dly_cfg = 2; vr0 = valid_rise_cnt;
        issue(F3_REMU, 32'd77, 32'd10, 5'd4);
        void'(sb.pop_back());
        @(posedge clk_i); #1;
        @(posedge clk_i); #1; flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
        @(negedge clk_i);
        check_val("coinc_idle", 64'(busy_o), 64'(0));
        check_val("coinc_no_rsp", 64'(valid_rise_cnt - vr0), 64'(0));

        // Flush in LAUNCH suppresses start
        s0 = start_cnt;
        issue(F3_DIVU, 32'd9, 32'd2, 5'd5);
        flush_i = 1'b1;
        void'(sb.pop_back());
        @(posedge clk_i); #1; flush_i = 1'b0;
        @(negedge clk_i);
        check_val("launch_flush_idle", 64'(busy_o), 64'(0));
        check_val("launch_flush_start", 64'(start_cnt - s0), 64'(0));

        // Flush in RESP with rsp_ready_i high: no handshake
        hs0 = hs_cnt;
        issue(3'b000, 32'd1, 32'd1, 5'd6);
        void'(sb.pop_back());
        flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
        @(negedge clk_i);
        check_val("resp_flush_valid", 64'(rsp_valid_o), 64'(0));
        check_val("resp_flush_hs", 64'(hs_cnt - hs0), 64'(0));

        // Reset mid-operation abandons silently; late done lands in IDLE
        dly_cfg = 5; vr0 = valid_rise_cnt;
        issue(F3_DIVU, 32'd1000, 32'd3, 5'd15);
        void'(sb.pop_back());
        @(posedge clk_i); #1; rst_ni = 1'b0;
        @(negedge clk_i);
        check_val("midrst_busy", 64'(busy_o), 64'(0));
        check_val("midrst_a", 64'(div_a_o), 64'(0));
        @(posedge clk_i); #1; rst_ni = 1'b1;
        repeat (6) @(negedge clk_i);
        check_val("midrst_no_rsp", 64'(valid_rise_cnt - vr0), 64'(0));
        check_val("midrst_idle", 64'(busy_o), 64'(0));

        // Stray done in IDLE is ignored
        @(posedge clk_i); #1; extra_done = 1'b1;
        @(posedge clk_i); #1; extra_done = 1'b0;
        @(negedge clk_i);
        check_val("stray_busy", 64'(busy_o), 64'(0));
        check_val("stray_valid", 64'(rsp_valid_o), 64'(0));

        // Randomised ops with random writeback back-pressure
        for (int n = 0; n < 24; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = (n % 6 == 0) ? 32'h8000_0000 : $urandom;
            case (n % 4)
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                default: b = $urandom_range(1, 1000);
            endcase
            dly_cfg = $urandom_range(1, 5);
            issue(op, a, b, 5'(n));
            wait_idle(1'b1);
        end

        check_val("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
